// File: rtl/fs_sync_pkg.sv
// Shared types and constants for the frame-sync receive sequencer.
package fs_sync_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHunt    = 2'd1,
        StBackoff = 2'd2,
        StRecv    = 2'd3
    } state_e;

    localparam logic [1:0] FAIL_NONE  = 2'd0;
    localparam logic [1:0] FAIL_RETRY = 2'd1;
    localparam logic [1:0] FAIL_OVF   = 2'd2;
    localparam logic [1:0] FAIL_TMO   = 2'd3;

    localparam int unsigned ERR_W = 8;
    localparam int unsigned TMR_W = 8;

endpackage

// File: rtl/fs_sync_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear and enable; at_max flags all-ones.
module sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    assign at_max = &cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fs_sync_ctrl.sv
// Frame-sync receive sequencer: hunt / backoff / receive with retry limit.
// Optional hunt watchdog compiled in with FS_SYNC_TIMEOUT_EN.
module fs_sync_ctrl
    import fs_sync_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned BIT_W     = 11,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             line_active,
    input  logic             synced_d,
    input  logic             sync_err_d,
    input  logic             eop,
    output logic             fs_rx_en,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [BIT_W-1:0] pkt_len,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

    state_e           state;
    logic [3:0]       retry_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             bit_max;
    logic             err_max;
    logic             tmo;

    logic start_ok;
    logic hunting;
    logic sync_ok;
    logic err_hit;
    logic bit_clr;
    logic bit_en;

    assign start_ok = (state == StIdle) && start && !abort;
    assign hunting  = (state == StHunt) && !abort;
    assign sync_ok  = hunting && synced_d;
    // Timeout outranks a sync error but not a sync.
    assign err_hit  = hunting && !synced_d && !tmo && sync_err_d;
    assign bit_clr  = start_ok || sync_ok;
    assign bit_en   = (state == StRecv) && !abort && line_active && !eop;

    assign fs_rx_en = (state == StHunt) && line_active;
    assign busy     = (state != StIdle);

    sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .en     (err_hit && !err_max),
        .cnt    (err_cnt),
        .at_max (err_max)
    );

    sat_cnt #(.W(BIT_W)) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (bit_clr),
        .en     (bit_en),
        .cnt    (bit_cnt),
        .at_max (bit_max)
    );

`ifdef FS_SYNC_TIMEOUT_EN
    logic [TMR_W-1:0] hunt_tmr;
    logic             unused_tmr_max;
    logic             in_hunt;

    assign in_hunt = (state == StHunt) || (state == StBackoff);
    // Fires in the TIMEOUT-th hunt cycle so the exit lands TIMEOUT edges after start.
    assign tmo     = in_hunt && (hunt_tmr == TMR_W'(TIMEOUT - 1));

    sat_cnt #(.W(TMR_W)) u_hunt_tmr (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_ok),
        .en     (in_hunt && !abort),
        .cnt    (hunt_tmr),
        .at_max (unused_tmr_max)
    );
`else
    logic [TMR_W-1:0] unused_timeout;

    assign unused_timeout = TMR_W'(TIMEOUT);
    assign tmo            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            retry_cnt <= '0;
            fail_code <= FAIL_NONE;
            pkt_len   <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            if (abort) begin
                state <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            state     <= StHunt;
                            retry_cnt <= '0;
                            fail_code <= FAIL_NONE;
                        end
                    end
                    StHunt: begin
                        if (synced_d) begin
                            state <= StRecv;
                        end else if (tmo) begin
                            state     <= StIdle;
                            fail      <= 1'b1;
                            fail_code <= FAIL_TMO;
                        end else if (sync_err_d) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            if (retry_cnt == RETRY_LAST) begin
                                state     <= StIdle;
                                fail      <= 1'b1;
                                fail_code <= FAIL_RETRY;
                            end else begin
                                state <= StBackoff;
                            end
                        end
                    end
                    StBackoff: begin
                        if (tmo) begin
                            state     <= StIdle;
                            fail      <= 1'b1;
                            fail_code <= FAIL_TMO;
                        end else begin
                            state <= StHunt;
                        end
                    end
                    StRecv: begin
                        if (eop) begin
                            state   <= StIdle;
                            done    <= 1'b1;
                            pkt_len <= bit_cnt;
                        end else if (line_active && bit_max) begin
                            state     <= StIdle;
                            fail      <= 1'b1;
                            fail_code <= FAIL_OVF;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/fs_sync_ctrl.md
# fs_sync_ctrl

Receive-side sequencer for the frame-sync (KJKJKJKK) detector. It enables the detector only while hunting for sync, retries after sync errors with a one-cycle backoff, and gives up after a configurable number of failures. After sync it counts payload bit-times until end-of-packet and reports length and status to the packet layer.

## Interface
Parameters:
- MAX_RETRY, 3: sync errors tolerated per attempt; the MAX_RETRY-th error ends the attempt with a failure (legal range 1..15).
- BIT_W, 11: width of the payload bit counter and pkt_len.
- TIMEOUT, 255: hunt watchdog limit in cycles (8-bit, legal 1..255); used only when the watchdog is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an attempt; ignored unless the state is IDLE.
- abort  in  1  return to IDLE next edge from any state; no done or fail pulse.
- line_active  in  1  PHY has a valid symbol this cycle.
- synced_d  in  1  detector: sync complete (combinational).
- sync_err_d  in  1  detector: sync error (combinational).
- eop  in  1  end of packet from the line decoder.
- fs_rx_en  out  1  detector enable (combinational).
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse: packet received.
- fail  out  1  one-cycle pulse: attempt failed.
- fail_code  out  2  0 none, 1 retries exhausted, 2 length overflow, 3 timeout. Held until the next accepted start.
- pkt_len  out  BIT_W  length of the last packet. Held until the next done.
- err_cnt  out  8  lifetime sync-error count. Saturates at 255 and is cleared only by rst.

## Operation
- States: IDLE, HUNT, BACKOFF, RECV.
- **IDLE**
  - fs_rx_en=0.
  - start → HUNT. The same edge clears retry_cnt, bit_cnt, hunt_tmr and fail_code.
- **HUNT**
  - fs_rx_en = line_active.
  - Priority: abort > synced_d > sync_err_d.
  - synced_d → RECV with bit_cnt=0.
  - sync_err_d increments err_cnt (saturating) and retry_cnt.
    - If retry_cnt+1 == MAX_RETRY → IDLE, fail, fail_code=1.
    - Otherwise → BACKOFF.
- **BACKOFF**
  - fs_rx_en=0 for exactly one cycle, then → HUNT.
  - retry_cnt is kept.
  - hunt_tmr keeps running.
- **RECV**
  - fs_rx_en=0.
  - bit_cnt increments on each cycle with line_active=1 and eop=0.
  - eop → IDLE. The same edge loads pkt_len=bit_cnt and asserts done. The eop cycle is not counted.
  - If bit_cnt is all-ones and line_active=1 and eop=0 → IDLE, fail, fail_code=2. pkt_len is unchanged.
- abort in any state → IDLE. Counters freeze, fail_code is unchanged, no pulse.
- start while busy: ignored.
- sync_err_d or synced_d outside HUNT: ignored. err_cnt does not increment.

## Timing
- Reset values: state IDLE, fs_rx_en=0, busy=0, done=0, fail=0, fail_code=0, pkt_len=0, err_cnt=0.
- All state changes occur on the clk edge that samples the cause.
- done and fail are registered. Each is high for the single cycle following that edge, i.e. coincident with busy=0 in IDLE.
- start at edge N puts the block in HUNT at N; fs_rx_en can first be 1 in cycle N+1.
- There is no combinational loop: fs_rx_en depends only on state and line_active, never on synced_d or sync_err_d.
- Back-to-back attempts: start may be accepted in the same cycle that done or fail is high.
- rst mid-operation: the block returns to IDLE on the next edge. All outputs take their reset values, including err_cnt and pkt_len.

## Configuration
- FS_SYNC_TIMEOUT_EN defined:
  - hunt_tmr (8-bit) counts every cycle in HUNT and BACKOFF from the accepted start.
  - When hunt_tmr reaches TIMEOUT while in HUNT or BACKOFF, and no synced_d is present, → IDLE with fail and fail_code=3.
  - Timeout has lower priority than synced_d and higher priority than sync_err_d.
- FS_SYNC_TIMEOUT_EN undefined:
  - No timer logic.
  - Hunting continues until sync, retries exhausted, or abort.
  - fail_code 3 is never produced.

## Structure
- Package fs_sync_pkg holds:
  - the state encoding (IDLE=0, HUNT=1, BACKOFF=2, RECV=3);
  - the fail_code constants FAIL_NONE, FAIL_RETRY, FAIL_OVF, FAIL_TMO;
  - the err_cnt width constant.
- One sub-module, sat_cnt: parameterised saturating up-counter with clear and enable, exposing an at_max output. It is instantiated for err_cnt, bit_cnt and hunt_tmr.
- All other logic lives in fs_sync_ctrl: the state register, next-state logic and output registers.

## Test plan
- **Successful packet:** rst; start; synced_d on the 3rd HUNT cycle; 20 line_active cycles; eop → done pulse, pkt_len=20, fail_code=0, busy=0.
- **Retries exhausted:** MAX_RETRY=3; start; sync_err_d three times, each separated by BACKOFF → fs_rx_en low for exactly one cycle after errors 1 and 2; fail with fail_code=1 after error 3; err_cnt=3.
- **Length overflow:** BIT_W=4; sync; 15 counted cycles, then line_active=1 with no eop → fail, fail_code=2, pkt_len unchanged from the previous packet.
- **Priority in HUNT:** synced_d and sync_err_d high together → RECV, err_cnt unchanged. Separately, abort with synced_d high → IDLE, no pulse.
- **Watchdog:** with FS_SYNC_TIMEOUT_EN and TIMEOUT=10, keep line_active=0 in HUNT → fail, fail_code=3, 10 cycles after start. Without the macro: busy stays 1 for 1000 cycles.
- **Saturation and reset:** drive 300 sync errors across attempts → err_cnt=255. Then rst during RECV → all outputs at reset values on the next cycle.
